board_update_sched: RTL and testbench
=====================================

Name: board_update_sched

Overview:
- Schedules transfer of the 4x4 2048 board state from game logic into the display-side shadow register file, so the VGA renderer never shows a half-updated board (no tearing).
- Accepts an update over a req/ack handshake and stages it.
- Commits the update tile-by-tile only in the first cycles of vertical blanking.
- Serves registered tile reads to the pixel renderer; sits between game FSM and the VGA timing/render block.

Parameters:
- TILES, 16, number of board tiles (4x4, row-major, index = row*4+col)
- TILE_W, 4, bits per tile (tile exponent; 0 = empty, n = 2^n)
- FCNT_W, 8, width of frame counter

Ports:
- dclk  in  1  pixel clock, 25 MHz
- clr  in  1  asynchronous reset, active-high
- vblank  in  1  high when vertical counter is outside active video (line <31 or >=511), from timing block
- upd_req  in  1  level request from game logic to commit a new board
- upd_board  in  TILES*TILE_W  new board; tile i at bits [i*TILE_W +: TILE_W]
- upd_ack  out  1  one-cycle pulse: board committed to shadow
- upd_busy  out  1  high whenever FSM is not IDLE
- rd_row  in  2  renderer tile row
- rd_col  in  2  renderer tile column
- rd_tile  out  TILE_W  shadow[rd_row*4+rd_col], registered
- frame_cnt  out  FCNT_W  count of vblank rising edges, wraps

Behaviour:
- Reset clr, asynchronous, active-high; clock dclk. All state updates on posedge dclk.
- Reset values: state=IDLE, staging=0, shadow=all 0 (empty board), copy index=0, vblank_d=0, upd_ack=0, upd_busy=0, rd_tile=0, frame_cnt=0.
- vb_edge = vblank & ~vblank_d; vblank_d registers vblank every cycle.
- frame_cnt increments by 1 on every vb_edge, modulo 2^FCNT_W (255 -> 0), in every state.
- FSM states: IDLE, PENDING, COPY, DONE.
- IDLE:
  - If upd_req=1, latch upd_board into staging and go to PENDING.
  - A vb_edge in the same cycle is ignored for this request; the commit waits for the next frame.
- PENDING:
  - Staging is frozen; upd_req and upd_board are ignored.
  - On vb_edge, set idx=0 and go to COPY.
- COPY:
  - Each cycle, shadow[idx] <= staging[idx] and idx increments.
  - When idx=TILES-1 is written, go to DONE. Lasts exactly TILES cycles.
  - Never aborts because vblank falls, since vblank lasts ~32000 cycles.
- DONE:
  - upd_ack=1 for this one cycle; go to IDLE.
- upd_busy = (state != IDLE), registered with state.
- Handshake:
  - The requester drops upd_req in the cycle after it sees upd_ack.
  - If upd_req is still high when the FSM returns to IDLE, it is accepted again as a new request.
- Latency:
  - Acceptance to ack = wait for next vb_edge + TILES cycles + 1.
  - With the edge k cycles after acceptance, ack is asserted k+TILES+1 cycles after acceptance.
- Read port:
  - rd_tile <= shadow[{rd_row,rd_col}], 1-cycle latency, every cycle regardless of FSM state.
  - A read in the same cycle as a write to the same index returns the old value.
- Reset mid-COPY: the shadow is cleared to all-empty; no ack is produced; the requester must re-request.

Decomposition:
- Shared package/include (alongside the vga definitions): TILES, TILE_W, board index macro (row*4+col), FSM state encodings, vblank line bounds (31, 511).
- One sub-module is natural: board_shadow_rf.
  - 16xTILE_W register file with async clear.
  - Single write port (we, widx, wdata) and one registered read port.
- FSM, staging register and frame counter stay in the top.

Test Plan:
- Reset: assert clr mid-frame -> rd_tile=0 for all 16 (row,col) reads; frame_cnt=0; upd_busy=0; upd_ack=0.
- Basic commit:
  - Stimulus: upd_req with tile i=i (0x FEDCBA9876543210) while vblank=0; vblank rises 100 cycles later.
  - Required: upd_busy=1 next cycle; shadow unchanged until the edge; ack pulse exactly 100+16+1 cycles after acceptance; reads give row2,col3 -> 11.
- Same-cycle edge:
  - Stimulus: upd_req accepted in the exact cycle of vb_edge.
  - Required: no COPY that frame; commit happens on the following vb_edge (one frame = 800*521 cycles later).
- Held request and frozen staging:
  - Stimulus: keep upd_req high after ack while changing upd_board in PENDING.
  - Required: the second request is accepted in IDLE the cycle after DONE; the value latched at acceptance is committed, not later upd_board changes.
- Reset mid-COPY: assert clr when idx=7 -> all tiles read 0; no upd_ack; FSM IDLE.
- Frame counter: 256 vblank rising edges -> frame_cnt wraps 255 -> 0; a vblank held high produces no extra increments.

Source files
------------

// File: rtl/board_update_sched_pkg.sv
// Shared definitions for the board update scheduler: board geometry, frame
// counter width, VGA vertical blanking line bounds and FSM state encodings.
package board_update_sched_pkg;

    localparam int TILES  = 16;  // 4x4 board, row-major
    localparam int TILE_W = 4;   // tile exponent: 0 = empty, n = 2^n
    localparam int FCNT_W = 8;   // frame counter width
    localparam int IDX_W  = 4;   // width of a tile index (0..15)

    // Vertical lines outside active video; vblank is high for line < LO or line >= HI.
    localparam int VB_LINE_LO = 31;
    localparam int VB_LINE_HI = 511;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2,
        ST_DONE    = 2'd3
    } sched_state_t;

    // Board index of a tile: row*4 + col.
    function automatic logic [IDX_W-1:0] board_idx(input logic [1:0] row,
                                                   input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/board_shadow_rf.sv
// Display-side shadow copy of the board: 16 x TILE_W register file with an
// asynchronous clear, one write port and one registered read port. A read of
// an index written in the same cycle returns the old contents.
module board_shadow_rf
    import board_update_sched_pkg::*;
(
    input  logic              dclk,
    input  logic              clr,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [TILE_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [TILE_W-1:0] rdata
);

    logic [TILE_W-1:0] mem [TILES];

    // Write port; clearing restores the empty board shown after reset.
    // NOTE: this storage is reset on purpose (a reset must blank the display
    // board), so it maps to flops rather than a RAM macro.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < TILES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            // NOTE: non-blocking updates make a same-cycle read see the old value.
            mem[widx] <= wdata;
        end
    end

    // Registered read port, active every cycle.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            rdata <= '0;
        end else begin
            rdata <= mem[ridx];
        end
    end

endmodule

// File: rtl/board_update_sched.sv
// Board update scheduler: accepts a new board from the game logic, holds it in
// a staging register and copies it tile-by-tile into the display shadow at
// the start of vertical blanking, so the renderer never shows a torn board.
module board_update_sched
    import board_update_sched_pkg::*;
(
    input  logic                      dclk,
    input  logic                      clr,
    input  logic                      vblank,
    input  logic                      upd_req,
    input  logic [TILES*TILE_W-1:0]   upd_board,
    output logic                      upd_ack,
    output logic                      upd_busy,
    input  logic [1:0]                rd_row,
    input  logic [1:0]                rd_col,
    output logic [TILE_W-1:0]         rd_tile,
    output logic [FCNT_W-1:0]         frame_cnt
);

    sched_state_t              state_q, state_d;
    logic [TILES*TILE_W-1:0]   staging_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      vblank_d;
    logic                      vb_edge;
    logic                      latch_staging;
    logic                      copy_we;
    logic                      copy_start;
    logic [TILE_W-1:0]         copy_data;

    assign vb_edge   = vblank & ~vblank_d;
    assign copy_data = staging_q[idx_q*TILE_W +: TILE_W];

    // Next-state logic and per-state control strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d       = state_q;
        latch_staging = 1'b0;
        copy_we       = 1'b0;
        copy_start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A vblank edge in the accept cycle is deliberately not used:
                // the commit waits for the next frame.
                if (upd_req) begin
                    latch_staging = 1'b1;
                    state_d       = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (vb_edge) begin
                    copy_start = 1'b1;
                    state_d    = ST_COPY;
                end
            end
            ST_COPY: begin
                // vblank lasts far longer than the copy, so it never aborts.
                copy_we = 1'b1;
                if (idx_q == IDX_W'(TILES - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with ack/busy registered alongside the state.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            state_q  <= ST_IDLE;
            upd_ack  <= 1'b0;
            upd_busy <= 1'b0;
        end else begin
            state_q  <= state_d;
            upd_ack  <= (state_d == ST_DONE);
            upd_busy <= (state_d != ST_IDLE);
        end
    end

    // Staging register (frozen outside IDLE) and copy index.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            staging_q <= '0;
            idx_q     <= '0;
        end else begin
            if (latch_staging) begin
                staging_q <= upd_board;
            end
            if (copy_start) begin
                idx_q <= '0;
            end else if (copy_we) begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    // vblank edge detector and wrapping frame counter, active in every state.
    always_ff @(posedge dclk or posedge clr) begin
        if (clr) begin
            vblank_d  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vblank_d <= vblank;
            if (vb_edge) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
            end
        end
    end

    board_shadow_rf u_shadow (
        .dclk  (dclk),
        .clr   (clr),
        .we    (copy_we),
        .widx  (idx_q),
        .wdata (copy_data),
        .ridx  (board_idx(rd_row, rd_col)),
        .rdata (rd_tile)
    );

endmodule

// File: tb/tb_board_update_sched.sv
// Directed bench for board_update_sched: table-driven shadow readback plus
// hand-written sequences for commit latency, same-cycle edge, held request,
// reset during copy and frame counter wrap. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_board_update_sched;
    import board_update_sched_pkg::*;

    logic                    dclk;
    logic                    clr;
    logic                    vblank;
    logic                    upd_req;
    logic [TILES*TILE_W-1:0] upd_board;
    logic                    upd_ack;
    logic                    upd_busy;
    logic [1:0]              rd_row;
    logic [1:0]              rd_col;
    logic [TILE_W-1:0]       rd_tile;
    logic [FCNT_W-1:0]       frame_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]        row;
        logic [1:0]        col;
        logic [TILE_W-1:0] exp;
    } rd_vec_t;

    rd_vec_t vecs[TILES];

    board_update_sched dut (
        .dclk      (dclk),
        .clr       (clr),
        .vblank    (vblank),
        .upd_req   (upd_req),
        .upd_board (upd_board),
        .upd_ack   (upd_ack),
        .upd_busy  (upd_busy),
        .rd_row    (rd_row),
        .rd_col    (rd_col),
        .rd_tile   (rd_tile),
        .frame_cnt (frame_cnt)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected readback table for a board given as a 64-bit constant.
    task automatic fill_vecs(input logic [63:0] board);
        for (int i = 0; i < TILES; i++) begin
            vecs[i].row = i[3:2];
            vecs[i].col = i[1:0];
            vecs[i].exp = board[i*4 +: 4];
        end
    endtask

    // Apply every (row,col) and compare rd_tile one cycle later.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < TILES; i++) begin
            rd_row = vecs[i].row;
            rd_col = vecs[i].col;
            @(negedge dclk);
            check($sformatf("%s_tile%0d", tag, i), rd_tile, vecs[i].exp);
        end
    endtask

    initial begin : main
        int first_ack;
        int second_ack;
        int ack_cnt;

        clr       = 1'b1;
        vblank    = 1'b0;
        upd_req   = 1'b0;
        upd_board = '0;
        rd_row    = 2'd0;
        rd_col    = 2'd0;

        // ---------------- Reset state ----------------
        repeat (3) @(negedge dclk);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_busy", upd_busy, 0);
        check("rst_ack", upd_ack, 0);
        clr = 1'b0;
        @(negedge dclk);
        fill_vecs(64'h0);
        run_vecs("rst");

        // ---------------- Basic commit, edge 100 cycles after accept ----------------
        upd_board = 64'hFEDCBA9876543210;
        upd_req   = 1'b1;
        rd_row    = 2'd2;
        rd_col    = 2'd3;
        first_ack = -1;
        ack_cnt   = 0;
        for (int c = 1; c <= 130; c++) begin
            @(negedge dclk);
            if (c == 1) check("basic_busy_next", upd_busy, 1);
            if (c == 100) begin
                check("basic_shadow_before_edge", rd_tile, 0);
                vblank = 1'b1;
            end
            if (c == 125) vblank = 1'b0;
            if (upd_ack) begin
                ack_cnt++;
                if (first_ack < 0) first_ack = c;
            end
            if (first_ack > 0 && c == first_ack + 1) begin
                upd_req = 1'b0;
                check("basic_idle_after_done", upd_busy, 0);
            end
        end
        check("basic_ack_latency", first_ack, 117);
        check("basic_ack_pulses", ack_cnt, 1);
        check("basic_frame_cnt", frame_cnt, 1);
        fill_vecs(64'hFEDCBA9876543210);
        run_vecs("basic");
        rd_row = 2'd2;
        rd_col = 2'd3;
        @(negedge dclk);
        check("basic_r2c3", rd_tile, 11);

        // ---------------- Accept in the same cycle as a vblank edge ----------------
        upd_board = 64'h0123456789ABCDEF;
        upd_req   = 1'b1;
        vblank    = 1'b1;
        first_ack = -1;
        ack_cnt   = 0;
        for (int c = 1; c <= 330; c++) begin
            @(negedge dclk);
            if (c == 1) begin
                check("same_busy", upd_busy, 1);
                check("same_frame_cnt", frame_cnt, 2);
            end
            if (c == 40) vblank = 1'b0;
            if (c == 150) check("same_no_copy_this_frame", rd_tile, 11);
            if (c == 300) vblank = 1'b1;
            if (upd_ack) begin
                ack_cnt++;
                if (first_ack < 0) first_ack = c;
            end
            if (first_ack > 0 && c == first_ack + 1) upd_req = 1'b0;
        end
        check("same_ack_next_frame", first_ack, 317);
        check("same_ack_pulses", ack_cnt, 1);
        vblank = 1'b0;
        fill_vecs(64'h0123456789ABCDEF);
        run_vecs("same");

        // ---------------- Held request, staging frozen in PENDING ----------------
        upd_board  = 64'h0F1E2D3C4B5A6978;
        upd_req    = 1'b1;
        first_ack  = -1;
        second_ack = -1;
        for (int c = 1; c <= 125; c++) begin
            @(negedge dclk);
            if (c == 20) vblank = 1'b1;
            if (c == 30) vblank = 1'b0;
            if (upd_ack) begin
                if (first_ack < 0) first_ack = c;
                else if (second_ack < 0) second_ack = c;
            end
            if (first_ack > 0 && c == first_ack + 1) begin
                check("held_idle_cycle", upd_busy, 0);
                upd_board = 64'h5555AAAA5555AAAA;
            end
            if (first_ack > 0 && c == first_ack + 2) check("held_reaccepted", upd_busy, 1);
            if (first_ack > 0 && c == first_ack + 3) upd_board = 64'hFFFFFFFFFFFFFFFF;
            if (c == 100) vblank = 1'b1;
            if (c == 105) vblank = 1'b0;  // falls mid-copy; copy must finish
            if (second_ack > 0 && c == second_ack + 1) upd_req = 1'b0;
        end
        check("held_first_ack", first_ack, 37);
        check("held_second_ack", second_ack, 117);
        fill_vecs(64'h5555AAAA5555AAAA);
        run_vecs("held");

        // ---------------- Reset in the middle of COPY (idx = 7) ----------------
        upd_board = 64'h7777777777777777;
        upd_req   = 1'b1;
        ack_cnt   = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge dclk);
            if (c == 10) vblank = 1'b1;
            if (c == 18) begin
                check("midcopy_busy_before", upd_busy, 1);
                clr     = 1'b1;
                upd_req = 1'b0;
            end
            if (c == 19) begin
                check("midcopy_busy_in_rst", upd_busy, 0);
                check("midcopy_cnt_in_rst", frame_cnt, 0);
                check("midcopy_rd_in_rst", rd_tile, 0);
            end
            if (c == 20) clr = 1'b0;
            if (c == 30) vblank = 1'b0;
            if (upd_ack) ack_cnt++;
        end
        check("midcopy_no_ack", ack_cnt, 0);
        check("midcopy_idle", upd_busy, 0);
        fill_vecs(64'h0);
        run_vecs("midcopy");

        // ---------------- Frame counter wrap ----------------
        clr = 1'b1;
        @(negedge dclk);
        clr = 1'b0;
        @(negedge dclk);
        check("fcnt_start", frame_cnt, 0);
        for (int e = 1; e <= 256; e++) begin
            vblank = 1'b1;
            @(negedge dclk);
            if (e == 1) begin
                repeat (20) @(negedge dclk);
                check("fcnt_held_high", frame_cnt, 1);
            end
            vblank = 1'b0;
            @(negedge dclk);
            if (e == 255) check("fcnt_255", frame_cnt, 255);
            if (e == 256) check("fcnt_wrap", frame_cnt, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
